// File: rtl/taillight_sched.sv
// taillight_sched: arbitrates left/right turn requests into full 3-step sweeps with guaranteed gaps
module taillight_sched #(
    parameter int GAP_CYCLES = 2,
    parameter int MAX_SWEEPS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_req,
    input  logic       right_req,
    output logic       left,
    output logic       right,
    output logic [1:0] phase,
    output logic       sweep_done,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, RUN_L, RUN_R, GAP} state_t;
    typedef enum logic {DIR_L, DIR_R} dir_t;

    state_t     state_q;
    dir_t       last_dir_q;
    logic [3:0] sweep_cnt_q;
    logic [3:0] gap_cnt_q;
    logic       eval, grant_l, grant_r, own, oth, cont;

    // grant decision, round-robin tie-break, and same-direction continuation test
    always_comb begin
        eval    = state_q == IDLE || (state_q == GAP && gap_cnt_q == 4'd0);
        grant_l = left_req && (!right_req || last_dir_q == DIR_R);
        grant_r = right_req && (!left_req || last_dir_q == DIR_L);
        own     = state_q == RUN_L ? left_req : right_req;
        oth     = state_q == RUN_L ? right_req : left_req;
        cont    = own && (!oth || MAX_SWEEPS == 0 || ({1'b0, sweep_cnt_q} + 5'd1) < 5'(MAX_SWEEPS));
    end

    // sequencer: state, counters and all registered outputs advance together
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_dir_q  <= DIR_R;
            sweep_cnt_q <= 4'd0;
            gap_cnt_q   <= 4'd0;
            left        <= 1'b0;
            right       <= 1'b0;
            phase       <= 2'd0;
            sweep_done  <= 1'b0;
            busy        <= 1'b0;
        end else if (eval) begin
            state_q     <= grant_l ? RUN_L : grant_r ? RUN_R : IDLE;
            sweep_cnt_q <= 4'd0;
            left        <= grant_l;
            right       <= grant_r;
            phase       <= (grant_l || grant_r) ? 2'd1 : 2'd0;
            sweep_done  <= 1'b0;
            busy        <= grant_l || grant_r;
            if (grant_l)
                last_dir_q <= DIR_L;
            else if (grant_r)
                last_dir_q <= DIR_R;
        end else if (state_q == GAP) begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
        end else if (phase != 2'd3) begin
            phase      <= phase + 2'd1;
            sweep_done <= phase == 2'd2;
        end else if (cont) begin
            phase       <= 2'd1;
            sweep_done  <= 1'b0;
            sweep_cnt_q <= sweep_cnt_q == 4'hF ? sweep_cnt_q : sweep_cnt_q + 4'd1;
        end else begin
            state_q    <= GAP;
            gap_cnt_q  <= 4'(GAP_CYCLES - 1);
            left       <= 1'b0;
            right      <= 1'b0;
            phase      <= 2'd0;
            sweep_done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_taillight_sched.sv
// tb_taillight_sched: directed and random requests against a sweep-level reference model
module tb_taillight_sched;
    localparam int G0 = 2, M0 = 4, G1 = 3, M1 = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       left_req = 1'b0;
    logic       right_req = 1'b0;
    logic       l0, r0, sd0, b0, l1, r1, sd1, b1;
    logic [1:0] p0, p1;

    int n_checks = 0;
    int n_fail = 0;

    int gp[2] = '{G0, G1};
    int mx[2] = '{M0, M1};
    int md[2];
    int st[2];
    int nsw[2];
    int grem[2];
    int ld[2];

    taillight_sched #(.GAP_CYCLES(G0), .MAX_SWEEPS(M0)) dut0 (
        .clk(clk), .reset(reset), .left_req(left_req), .right_req(right_req),
        .left(l0), .right(r0), .phase(p0), .sweep_done(sd0), .busy(b0)
    );

    taillight_sched #(.GAP_CYCLES(G1), .MAX_SWEEPS(M1)) dut1 (
        .clk(clk), .reset(reset), .left_req(left_req), .right_req(right_req),
        .left(l1), .right(r1), .phase(p1), .sweep_done(sd1), .busy(b1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // md: 0 none, 1 left sweep, 2 right sweep; grem: gap cycles still to show
    task automatic model_step(input int k);
        int g;
        bit own, oth;
        if (reset) begin
            md[k] = 0; st[k] = 0; nsw[k] = 0; grem[k] = 0; ld[k] = 2;
            return;
        end
        if (md[k] != 0) begin
            if (st[k] < 3) st[k]++;
            else begin
                own = md[k] == 1 ? left_req : right_req;
                oth = md[k] == 1 ? right_req : left_req;
                nsw[k]++;
                if (own && (!oth || mx[k] == 0 || nsw[k] < mx[k])) st[k] = 1;
                else begin
                    md[k] = 0; st[k] = 0; grem[k] = gp[k];
                end
            end
        end else if (grem[k] > 1) grem[k]--;
        else begin
            grem[k] = 0;
            g = (left_req && right_req) ? (ld[k] == 1 ? 2 : 1) : left_req ? 1 : right_req ? 2 : 0;
            if (g != 0) begin
                md[k] = g; st[k] = 1; nsw[k] = 0; ld[k] = g;
            end
        end
    endtask

    function automatic int expv(input int k);
        return {26'd0, md[k] == 1, md[k] == 2, 2'(st[k]), md[k] != 0 && st[k] == 3, md[k] != 0 || grem[k] > 0};
    endfunction

    task automatic cyc(input bit rst, input bit lr, input bit rr);
        @(negedge clk);
        reset = rst; left_req = lr; right_req = rr;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk("dut0_outs", {26'd0, l0, r0, p0, sd0, b0}, expv(0));
        chk("dut1_outs", {26'd0, l1, r1, p1, sd1, b1}, expv(1));
        chk("excl", int'((l0 & r0) | (l1 & r1)), 0);
    endtask

    initial begin
        int sd_cnt;
        bit lr, rr;
        md = '{0, 0}; st = '{0, 0}; nsw = '{0, 0}; grem = '{0, 0}; ld = '{2, 2};
        cyc(1, 0, 0);
        chk("rst_busy", int'(b0), 0);
        chk("rst_phase", int'(p0), 0);
        cyc(0, 1, 0);
        chk("first_left", int'(l0), 1);
        chk("first_phase", int'(p0), 1);
        sd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0);
            sd_cnt += int'(sd0);
        end
        chk("drop_sd_once", sd_cnt, 1);
        chk("idle_busy", int'(b0), 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 1);
            chk("cont_right_noleft", int'(l0), 0);
        end
        for (int i = 0; i < 10; i++) cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 1, 1);
        chk("both_left_first", int'(l0), 1);
        for (int i = 0; i < 40; i++) cyc(0, 1, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("right_phase2", int'(p0), 2);
        cyc(1, 1, 1);
        chk("rst_mid_right", int'(r0), 0);
        chk("rst_mid_busy", int'(b0), 0);
        cyc(0, 1, 1);
        chk("after_rst_left", int'(l0), 1);
        for (int i = 0; i < 30; i++) begin
            cyc(0, 1, 1);
            chk("max0_never_gap", int'(l1), 1);
        end
        for (int i = 0; i < 3000; i++) begin
            lr = ($urandom_range(0, 3) != 0) ? left_req : ~left_req;
            rr = ($urandom_range(0, 3) != 0) ? right_req : ~right_req;
            cyc($urandom_range(0, 199) == 0, lr, rr);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
